imem_loader: RTL
================

# imem_loader

Byte-stream program loader that fills the pipelined core's byte-addressed instruction memory and holds the core until the program image is complete. It replaces the bench-side file preload with a synthesizable write path. It accepts bytes over a valid/ready stream and writes them to consecutive instruction-memory addresses. A partial final word is zero-padded to a 4-byte boundary, and `core_hold` is released once the image is in place.

## Interface
- `ADDR_W`, default 8: instruction-memory byte-address width.
- `DEPTH`, default 256: memory size in bytes; must be a multiple of 4 and ≤ 2^ADDR_W.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; level sampled per cycle.
- `in_valid`  in  1  stream byte valid.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge with `in_valid && in_ready`.
- `in_data`  in  8  stream byte.
- `in_last`  in  1  qualifies the final byte of the image.
- `mem_we`  out  1  instruction-memory byte write enable.
- `mem_addr`  out  ADDR_W  write byte address.
- `mem_wdata`  out  8  write byte.
- `core_hold`  out  1  holds the core (PC enable / pipeline reset) while high.
- `done`  out  1  image loaded and aligned.
- `overflow`  out  1  image exceeded DEPTH bytes.
- `byte_count`  out  ADDR_W+1  bytes written so far, including pad bytes.

## Operation
- States: IDLE, LOAD, PAD, DONE, ERR.
- Reset values: state IDLE, `core_hold`=1, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `overflow`=0, `byte_count`=0.
- IDLE:
  - `start`=1 → LOAD.
  - `byte_count` clears to 0.
- LOAD:
  - `in_ready`=1, decoded combinationally from state.
  - Each transfer with `byte_count` < DEPTH writes `in_data` to address `byte_count`, then `byte_count` increments.
  - Transfer with `in_last`=1: new count a multiple of 4 → DONE; otherwise → PAD.
  - Transfer with `byte_count`==DEPTH: the byte is discarded, nothing is written, next state is ERR.
  - `start` is ignored.
- PAD:
  - `in_ready`=0.
  - Writes one 0x00 byte per cycle at `byte_count` and increments the count.
  - Exits to DONE on the cycle the count reaches a multiple of 4. An all-zero word executes as a no-op.
- DONE:
  - `done`=1, `core_hold`=0, `in_ready`=0.
  - `start`=1 → LOAD with `byte_count` cleared, `done`=0, `core_hold`=1.
- ERR:
  - `overflow`=1, `core_hold`=1, `in_ready`=0.
  - `start`=1 → LOAD with `byte_count` cleared and `overflow` cleared.
- Byte order: stream order maps to ascending addresses. The loader does no endian swapping; the core assembles the 4 bytes per word.

## Timing
- Write outputs are registered. A transfer on edge k drives `mem_we`=1, `mem_addr`=pre-increment count, and `mem_wdata` during cycle k+1. `mem_we` is low in any cycle with no pending write.
- `byte_count` updates on the same edge as the transfer or pad write.
- PAD emits its first pad write in the cycle after the edge that moves to PAD.
- `done` and `core_hold` change on the edge after the last data or pad write is issued. The memory therefore sees its final write no later than the cycle `core_hold` falls.
- `start` and `in_valid` asserted together in IDLE: the byte is not accepted that cycle, because `in_ready` is still 0.
- Asserting `reset` mid-load:
  - All outputs return to reset values immediately.
  - Memory contents stay as partially written.
  - The next `start` reloads from address 0.
- `byte_count` saturates at DEPTH and never wraps.

## Structure
- Package `imem_loader_pkg`: state enum (IDLE, LOAD, PAD, DONE, ERR), `WORD_BYTES`=4, pad byte constant 8'h00.
- Single module, no sub-modules. The FSM, counter and output registers live in one file.

## Test plan
- Reset asserted → `core_hold`=1, `in_ready`=0, `done`=0, `overflow`=0, `byte_count`=0, `mem_we`=0.
- `start`, then 8 contiguous bytes E3 A0 10 05 E3 A0 20 03 with `in_last` on the 8th → 8 writes at addresses 0..7 in order, no pad, `byte_count`=8, `done`=1, `core_hold`=0.
- 6 bytes with `in_last` on the 6th → writes at 0..5, then pad writes 0x00 at 6 and 7, `byte_count`=8, then `done`.
- `in_valid` gapped (1,0,0,1,1,0,1, last on the 4th byte) → exactly 4 writes, each the cycle after its transfer, none during gaps.
- DEPTH=16 with 17 bytes → 16 writes at 0..15, 17th not written, `overflow`=1, `core_hold`=1; `start` → LOAD with `overflow`=0 and `byte_count`=0.
- Reset asserted after 3 bytes → IDLE, `byte_count`=0; `start` plus 4 bytes → writes at 0..3, then `done`.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
// Word geometry drives the pad-to-boundary rule in the loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      DONE,
      ERR
   } state_t;

   localparam int         WORD_BYTES = 4;
   localparam int         OFS_W      = $clog2(WORD_BYTES);
   localparam logic [7:0] PAD_BYTE   = 8'h00;

endpackage

// File: rtl/imem_loader.sv
// Streams bytes into consecutive instruction-memory addresses, zero-pads to a word boundary and then releases the core.
// Writes appear one cycle after their transfer; in_ready is high only while loading, so the source stalls during pad/done/err.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   byte_count
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

   state_t              state, state_nxt;
   logic [ADDR_W:0]     count_q, count_nxt;
   logic                we_q, we_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [7:0]          wdata_q, wdata_nxt;
   logic                xfer;
   logic                aligned_nxt;

   assign in_ready    = (state == LOAD);
   assign xfer        = in_valid && in_ready;
   assign aligned_nxt = (count_nxt[OFS_W-1:0] == '0);

   always_comb begin
      state_nxt = state;
      count_nxt = count_q;
      we_nxt    = 1'b0;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;

      case (state)
         IDLE: begin
            count_nxt = '0;
            if (start) begin
               state_nxt = LOAD;
            end
         end

         LOAD: begin
            if (xfer) begin
               // A byte arriving with the memory already full is dropped; the count saturates at DEPTH.
               if (count_q == DEPTH_CNT) begin
                  state_nxt = ERR;
               end else begin
                  we_nxt    = 1'b1;
                  addr_nxt  = count_q[ADDR_W-1:0];
                  wdata_nxt = in_data;
                  count_nxt = count_q + CNT_ONE;
                  if (in_last) begin
                     state_nxt = aligned_nxt ? DONE : PAD;
                  end
               end
            end
         end

         PAD: begin
            // DEPTH is word-aligned, so padding can never run past the end of memory.
            we_nxt    = 1'b1;
            addr_nxt  = count_q[ADDR_W-1:0];
            wdata_nxt = PAD_BYTE;
            count_nxt = count_q + CNT_ONE;
            if (aligned_nxt) begin
               state_nxt = DONE;
            end
         end

         DONE, ERR: begin
            if (start) begin
               state_nxt = LOAD;
               count_nxt = '0;
            end
         end

         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state   <= state_nxt;
         count_q <= count_nxt;
         we_q    <= we_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign byte_count = count_q;
   assign done       = (state == DONE);
   assign overflow   = (state == ERR);
   assign core_hold  = (state != DONE);

endmodule
